// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter and memory-clear sequencer for the
// shared 64x8 data RAM. Requester A is the CPU load/store path, requester B
// is the loader/debug port. Every access takes three cycles:
// IDLE (grant) -> ACC (RAM access) -> RESP (ack pulse).
// The clear sequencer zero-fills every word, so the RAM's own reset is unused.
// Optional build macro: RAM_ARB_FIXED_PRIORITY_EN. When it is defined,
// A always wins simultaneous requests. When it is undefined, simultaneous
// requests are resolved round-robin.
module ram_arbiter #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          reqA,
  input  logic          weA,
  input  logic [AW-1:0] addrA,
  input  logic [DW-1:0] wdataA,
  output logic          ackA,
  output logic [DW-1:0] rdataA,
  input  logic          reqB,
  input  logic          weB,
  input  logic [AW-1:0] addrB,
  input  logic [DW-1:0] wdataB,
  output logic          ackB,
  output logic [DW-1:0] rdataB,
  input  logic          clr_start,
  output logic          clr_done,
  output logic          busy,
  output logic [AW-1:0] ram_readAddress,
  output logic [AW-1:0] ram_writeAddress,
  output logic [DW-1:0] ram_WriteData,
  output logic          ram_readEn,
  output logic          ram_writeEn,
  input  logic [DW-1:0] ram_ReadData
);

  typedef enum logic [1:0] {IDLE, ACC, RESP, CLEAR} stateT;

  stateT         state;
  stateT         stateNext;
  logic          gntB;
  logic          gntBNext;
  logic          grantEn;
  logic          tieSeen;
  logic          accWe;
  logic [AW-1:0] accAddr;
  logic [DW-1:0] accData;
  logic          clrPend;
  logic [AW-1:0] clrCnt;
  logic          clrLast;
  logic          tieWinnerB;

  assign clrLast = (clrCnt == {AW{1'b1}});

`ifdef RAM_ARB_FIXED_PRIORITY_EN
  assign tieWinnerB = 1'b0;
`else
  logic lastGrantB;

  // Remember who won the last tie; B counts as the last winner after reset, so A wins the first tie
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      lastGrantB <= 1'b1;
    end else if (tieSeen) begin
      lastGrantB <= gntBNext;
    end
  end

  assign tieWinnerB = ~lastGrantB;
`endif

  // Next state and grant selection; a pending clear beats any request
  always_comb begin
    stateNext = state;
    gntBNext  = gntB;
    grantEn   = 1'b0;
    tieSeen   = 1'b0;
    case (state)
      IDLE: begin
        if (clrPend) begin
          stateNext = CLEAR;
        end else if (reqA && reqB) begin
          stateNext = ACC;
          grantEn   = 1'b1;
          tieSeen   = 1'b1;
          gntBNext  = tieWinnerB;
        end else if (reqA) begin
          stateNext = ACC;
          grantEn   = 1'b1;
          gntBNext  = 1'b0;
        end else if (reqB) begin
          stateNext = ACC;
          grantEn   = 1'b1;
          gntBNext  = 1'b1;
        end
      end
      ACC:     stateNext = RESP;
      RESP:    stateNext = IDLE;
      CLEAR:   if (clrLast) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register, plus the granted requester's command latched on the IDLE->ACC edge
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      gntB    <= 1'b0;
      accWe   <= 1'b0;
      accAddr <= '0;
      accData <= '0;
    end else begin
      state <= stateNext;
      if (grantEn) begin
        gntB    <= gntBNext;
        accWe   <= gntBNext ? weB    : weA;
        accAddr <= gntBNext ? addrB  : addrA;
        accData <= gntBNext ? wdataB : wdataA;
      end
    end
  end

  // A clear request is remembered until CLEAR is entered; a new pulse on that same edge is kept
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clrPend <= 1'b0;
    end else if (clr_start) begin
      clrPend <= 1'b1;
    end else if (state == IDLE && stateNext == CLEAR) begin
      clrPend <= 1'b0;
    end
  end

  // Clear address counter; it wraps back to 0 after the last word, ready for the next clear
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clrCnt <= '0;
    end else if (state == CLEAR) begin
      clrCnt <= clrCnt + 1'b1;
    end else if (state == IDLE && stateNext == CLEAR) begin
      clrCnt <= '0;
    end
  end

  // clr_done pulses during the first IDLE cycle after the last word is cleared
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clr_done <= 1'b0;
    end else begin
      clr_done <= (state == CLEAR) && clrLast;
    end
  end

  // Capture read data for the granted requester; a write leaves its read data untouched
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rdataA <= '0;
      rdataB <= '0;
    end else if (state == ACC && !accWe) begin
      if (gntB) begin
        rdataB <= ram_ReadData;
      end else begin
        rdataA <= ram_ReadData;
      end
    end
  end

  // RAM controls decode only from registered state, so asserting reset drops the enables at once
  always_comb begin
    ackA             = (state == RESP) && !gntB;
    ackB             = (state == RESP) && gntB;
    busy             = (state != IDLE) || clrPend;
    ram_readEn       = (state == ACC) && !accWe;
    ram_writeEn      = ((state == ACC) && accWe) || (state == CLEAR);
    ram_readAddress  = '0;
    ram_writeAddress = '0;
    ram_WriteData    = '0;
    if (ram_readEn) begin
      ram_readAddress = accAddr;
    end
    if (state == CLEAR) begin
      ram_writeAddress = clrCnt;
    end else if (state == ACC && accWe) begin
      ram_writeAddress = accAddr;
      ram_WriteData    = accData;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter (default round-robin build).
// A small behavioural 64x8 RAM model is connected to the RAM-side ports.
module tb_ram_arbiter;

  logic       Clk;
  logic       Reset;
  logic       reqA, weA, ackA, reqB, weB, ackB;
  logic [5:0] addrA, addrB;
  logic [7:0] wdataA, wdataB, rdataA, rdataB;
  logic       clr_start, clr_done, busy;
  logic [5:0] ram_readAddress, ram_writeAddress;
  logic [7:0] ram_WriteData, ram_ReadData;
  logic       ram_readEn, ram_writeEn;

  logic [7:0] mem [64];

  int assertCount = 0;
  int failCount   = 0;
  int zeroWrites;
  int doneCount;
  logic expB;

  ram_arbiter #(.AW(6), .DW(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .reqA(reqA), .weA(weA), .addrA(addrA), .wdataA(wdataA), .ackA(ackA), .rdataA(rdataA),
    .reqB(reqB), .weB(weB), .addrB(addrB), .wdataB(wdataB), .ackB(ackB), .rdataB(rdataB),
    .clr_start(clr_start), .clr_done(clr_done), .busy(busy),
    .ram_readAddress(ram_readAddress), .ram_writeAddress(ram_writeAddress),
    .ram_WriteData(ram_WriteData), .ram_readEn(ram_readEn), .ram_writeEn(ram_writeEn),
    .ram_ReadData(ram_ReadData)
  );

  // Free-running clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // RAM model: synchronous write; combinational read (the floating bus is modelled as 0)
  always @(posedge Clk) begin
    if (ram_writeEn) mem[ram_writeAddress] <= ram_WriteData;
  end
  assign ram_ReadData = ram_readEn ? mem[ram_readAddress] : 8'h00;

  // Advance n clock edges and settle 1 time unit past the last one
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    Reset = 1'b0; reqA = 0; weA = 0; addrA = 0; wdataA = 0;
    reqB = 0; weB = 0; addrB = 0; wdataB = 0; clr_start = 0;
    applyStimulus(2);
    checkOutput("rst_ackA", ackA, 0);
    checkOutput("rst_rdataA", rdataA, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_writeEn", ram_writeEn, 0);
    checkOutput("rst_readEn", ram_readEn, 0);
    checkOutput("rst_clr_done", clr_done, 0);
    Reset = 1'b1;
    applyStimulus(1);

    // Reset asserted mid-clear, while word 20 is being written
    clr_start = 1;
    applyStimulus(1);
    clr_start = 0;
    checkOutput("pend_busy", busy, 1);
    applyStimulus(1);
    checkOutput("clr0_writeEn", ram_writeEn, 1);
    checkOutput("clr0_addr", ram_writeAddress, 0);
    applyStimulus(20);
    checkOutput("clr20_addr", ram_writeAddress, 20);
    Reset = 1'b0;
    #1;
    checkOutput("rstclr_writeEn", ram_writeEn, 0);
    checkOutput("rstclr_addr", ram_writeAddress, 0);
    checkOutput("rstclr_busy", busy, 0);
    checkOutput("rstclr_clr_done", clr_done, 0);
    applyStimulus(1);
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      checkOutput("post_rst_busy", busy, 0);
      checkOutput("post_rst_clr_done", clr_done, 0);
    end

    // A writes 0xA5 to address 5
    reqA = 1; weA = 1; addrA = 6'd5; wdataA = 8'hA5;
    applyStimulus(1);
    checkOutput("wrA_writeEn", ram_writeEn, 1);
    checkOutput("wrA_addr", ram_writeAddress, 5);
    checkOutput("wrA_data", ram_WriteData, 8'hA5);
    checkOutput("wrA_readEn", ram_readEn, 0);
    checkOutput("wrA_early_ack", ackA, 0);
    applyStimulus(1);
    checkOutput("wrA_ack", ackA, 1);
    checkOutput("wrA_rdata_kept", rdataA, 0);
    reqA = 0;
    applyStimulus(1);
    checkOutput("wrA_ack_drop", ackA, 0);

    // A reads address 5 back
    reqA = 1; weA = 0;
    applyStimulus(1);
    checkOutput("rdA_readEn", ram_readEn, 1);
    checkOutput("rdA_readAddr", ram_readAddress, 5);
    checkOutput("rdA_writeEn", ram_writeEn, 0);
    applyStimulus(1);
    checkOutput("rdA_ack", ackA, 1);
    checkOutput("rdA_rdata", rdataA, 8'hA5);
    checkOutput("rdA_readEn_one", ram_readEn, 0);
    reqA = 0;
    applyStimulus(1);
    checkOutput("rdA_rdata_held", rdataA, 8'hA5);
    checkOutput("rdA_ack_drop", ackA, 0);

    // Fresh reset so A wins the first tie, then A and B request together
    Reset = 1'b0;
    #1;
    Reset = 1'b1;
    reqA = 1; weA = 1; addrA = 6'd6; wdataA = 8'h11;
    reqB = 1; weB = 0; addrB = 6'd5;
    for (int t = 0; t < 4; t++) begin
      expB = (t % 2) == 1;
      applyStimulus(2);
      checkOutput("rr_ackA", ackA, !expB);
      checkOutput("rr_ackB", ackB, expB);
      if (expB) checkOutput("rr_rdataB", rdataB, 8'hA5);
      if (t == 3) begin
        reqA = 0; reqB = 0;
      end
      applyStimulus(1);
    end

    // clr_start arrives while a B write is in ACC; the write still completes
    reqB = 1; weB = 1; addrB = 6'd9; wdataB = 8'h77;
    applyStimulus(1);
    clr_start = 1;
    checkOutput("bwr_writeEn", ram_writeEn, 1);
    checkOutput("bwr_addr", ram_writeAddress, 9);
    applyStimulus(1);
    clr_start = 0; reqB = 0;
    checkOutput("bwr_ackB", ackB, 1);
    checkOutput("bwr_busy", busy, 1);
    applyStimulus(1);
    checkOutput("idle_pend_writeEn", ram_writeEn, 0);
    checkOutput("idle_pend_busy", busy, 1);
    reqA = 1; weA = 0; addrA = 6'd5;
    applyStimulus(1);
    for (int i = 0; i < 64; i++) begin
      checkOutput("clr_writeEn", ram_writeEn, 1);
      checkOutput("clr_addr", ram_writeAddress, i);
      checkOutput("clr_data", ram_WriteData, 0);
      checkOutput("clr_no_ackA", ackA, 0);
      checkOutput("clr_no_done", clr_done, 0);
      applyStimulus(1);
    end
    checkOutput("clr_done_pulse", clr_done, 1);
    checkOutput("clr_done_busy", busy, 0);
    applyStimulus(1);
    checkOutput("clr_done_single", clr_done, 0);
    checkOutput("held_ackA_early", ackA, 0);
    applyStimulus(1);
    checkOutput("held_ackA", ackA, 1);
    checkOutput("cleared_rdataA", rdataA, 8'h00);
    reqA = 0;
    applyStimulus(1);

    // Two clear requests 10 cycles apart produce two full clears
    zeroWrites = 0;
    doneCount  = 0;
    for (int c = 0; c < 200; c++) begin
      clr_start = (c == 0) || (c == 10);
      applyStimulus(1);
      if (ram_writeEn && ram_WriteData == 8'h00) zeroWrites++;
      if (clr_done) doneCount++;
    end
    clr_start = 0;
    checkOutput("dbl_zero_writes", zeroWrites, 128);
    checkOutput("dbl_done_pulses", doneCount, 2);
    checkOutput("dbl_busy_end", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the 64x8 data RAM (6-bit address, 8-bit data, combinational read gated by readEn, write on posedge Clk).
- Requester A (CPU load/store) and requester B (loader/debug port) share the single RAM.
- Includes a memory-clear sequencer that zero-fills all 64 words, so the RAM's own synchronous Reset input is tied low at top level.

Parameters:
- AW, 6, RAM address width; depth = 2**AW.
- DW, 8, RAM data width.

Ports:
- Clk  in  1  clock, all state on posedge.
- Reset  in  1  asynchronous, active-low reset.
- reqA  in  1  A access request; held until ackA.
- weA  in  1  A: 1 = write, 0 = read; stable while reqA.
- addrA  in  AW  A address.
- wdataA  in  DW  A write data.
- ackA  out  1  one-cycle completion pulse for A.
- rdataA  out  DW  A read data; registered, valid from ackA, held until A's next read completes.
- reqB, weB, addrB, wdataB, ackB, rdataB  same as A, for requester B.
- clr_start  in  1  one-cycle pulse requesting a full memory clear.
- clr_done  out  1  one-cycle pulse after word 63 is cleared.
- busy  out  1  state != IDLE, or clear pending.
- ram_readAddress  out  AW  to RAM.
- ram_writeAddress  out  AW  to RAM.
- ram_WriteData  out  DW  to RAM.
- ram_readEn  out  1  to RAM.
- ram_writeEn  out  1  to RAM.
- ram_ReadData  in  DW  from RAM; combinational, Z when readEn = 0.

Behaviour:
- States: IDLE, ACC, RESP, CLEAR. Reset state is IDLE.
- Values under reset: ackA/B = 0, clr_done = 0, rdataA/B = 0, busy = 0, all ram_* outputs = 0, last_grant = B (A wins the first tie), clr_pend = 0, clr_cnt = 0.
- RAM control outputs decode combinationally from registered state. Asserting Reset therefore drops ram_writeEn/ram_readEn immediately, mid-transfer or mid-clear.
- clr_pend is set by clr_start in any state and cleared on entry to CLEAR.
- IDLE:
  - clr_pend = 1 -> CLEAR, clr_cnt = 0. Clear has priority over requests.
  - Else one request -> ACC with grant to that requester.
  - Else both requests -> ACC with grant to the requester that is not last_grant; last_grant is updated.
  - Else stay in IDLE.
  - Granted requester's weA/addrA/wdataA (or B) are latched into internal registers on the IDLE->ACC edge.
- ACC, exactly one cycle:
  - Write: ram_writeAddress = latched address, ram_WriteData = latched data, ram_writeEn = 1, ram_readEn = 0. The RAM commits at the ACC->RESP edge.
  - Read: ram_readAddress = latched address, ram_readEn = 1, ram_writeEn = 0. ram_ReadData is captured into the granted rdataX at the ACC->RESP edge; a write leaves rdataX unchanged.
  - -> RESP.
- RESP, one cycle: granted ackX = 1. -> IDLE.
  - Requester must deassert reqX in the cycle ackX is seen. A req still high in the following IDLE is a new request.
- Latency: request sampled at edge n; RAM access in cycle n..n+1; ack and rdata visible in cycle n+1..n+2. Minimum 3 cycles per transaction.
- Peak throughput is one access per 3 cycles. Strict alternation when both requesters are continuously requesting; no starvation.
- CLEAR:
  - Each cycle: ram_writeEn = 1, ram_writeAddress = clr_cnt, ram_WriteData = 0; clr_cnt increments.
  - At clr_cnt = 2**AW-1: the write completes, -> IDLE, clr_done pulses in the first IDLE cycle.
  - clr_cnt wraps to 0.
  - Requests during CLEAR wait; their acks are not issued.
  - clr_start during CLEAR sets clr_pend, causing a second full clear afterwards.
- Both RAM address outputs are 0 whenever the corresponding enable is 0.

Optional Feature:
- Macro RAM_ARB_FIXED_PRIORITY_EN.
- Defined: A always wins simultaneous requests. last_grant register is removed. B can starve.
- Undefined (default): round-robin as above.
- Clear priority over requests is unchanged in both builds.

Test Plan:
- Reset low mid-CLEAR (clr_cnt = 20) -> ram_writeEn = 0 immediately, all outputs at reset values. Reset released -> IDLE, busy = 0, no clr_done.
- reqA with weA = 1, addrA = 6'd5, wdataA = 8'hA5, then reqA read of addr 5 -> first ackA 2 cycles after sampling. Second ackA has rdataA = 8'hA5, ram_readEn high exactly one cycle.
- reqA and reqB both held from the same cycle, B reading addr 5 -> grants A, B, A, B (default build). ackB carries rdataB = 8'hA5. With RAM_ARB_FIXED_PRIORITY_EN -> A only while reqA stays high.
- clr_start pulse while a B write is in ACC -> B write completes and ackB is issued, then 64 consecutive writes of 0 to addresses 0..63. clr_done pulses once; a subsequent read of addr 5 returns 8'h00.
- reqA asserted during CLEAR -> no ackA until clr_done. ackA follows 2 cycles after the IDLE in which clr_done pulses.
- Two clr_start pulses 10 cycles apart -> 128 zero writes, two clr_done pulses.
